// File: rtl/rdout_pkg.sv
// rtl/rdout_pkg.sv - shared register map, status bit positions and bank descriptor type
package rdout_pkg;

  localparam logic [11:0] REG_STATUS  = 12'd0;
  localparam logic [11:0] REG_LEN     = 12'd1;
  localparam logic [11:0] REG_CH      = 12'd2;
  localparam logic [11:0] REG_RELEASE = 12'd3;
  localparam logic [11:0] REG_CTRL    = 12'd4;

  localparam int STAT_BUSY_BIT    = 0;
  localparam int STAT_OVF_BIT     = 1;
  localparam int STAT_CNT_LSB     = 12;
  localparam int CTRL_FLUSH_BIT   = 0;
  localparam int CTRL_CLR_OVF_BIT = 1;

  // Channel field is sized for the widest supported tag; narrower tags are zero-extended.
  localparam int DESC_CH_W = 8;

  typedef struct packed {
    logic [15:0]          len;
    logic [DESC_CH_W-1:0] ch;
  } desc_t;

  function automatic logic [15:0] clamp_len(input logic [15:0] len, input int addr_w);
    logic [16:0] lim;
    lim = 17'(1) << addr_w;
    return ({1'b0, len} > lim) ? lim[15:0] : len;
  endfunction

endpackage

// File: rtl/rdout_bank_mgr_if.sv
// rtl/rdout_bank_mgr_if.sv - writer port and host register bus of the readout bank manager
interface rdout_bank_mgr_if #(
  parameter int ADDR_W = 10,
  parameter int CH_W   = 2
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              wr_commit;
  logic [15:0]       wr_len;
  logic [CH_W-1:0]   wr_ch;
  logic              wr_busy;
  logic [11:0]       y_adr;
  logic              y_wr;
  logic [15:0]       y_wr_data;
  logic [15:0]       y_rd_data;
  logic              y_rd_hit;
  logic              irq;

  modport master (
    output wr_en, wr_addr, wr_data, wr_commit, wr_len, wr_ch, y_adr, y_wr, y_wr_data,
    input  wr_busy, y_rd_data, y_rd_hit, irq
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_commit, wr_len, wr_ch, y_adr, y_wr, y_wr_data,
    output wr_busy, y_rd_data, y_rd_hit, irq
  );
endinterface

// File: rtl/rdout_bank_ram.sv
// rtl/rdout_bank_ram.sv - simple dual-port bank storage, one write port, registered read port
module rdout_bank_ram #(
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);
  logic [31:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/rdout_bank_mgr.sv
// rtl/rdout_bank_mgr.sv - circular queue of readout banks filled by a writer, drained through host registers
module rdout_bank_mgr
  import rdout_pkg::*;
#(
  parameter int          N_BANK   = 2,
  parameter int          ADDR_W   = 10,
  parameter int          N_CH     = 4,
  parameter logic [11:0] REG_BASE = 12'hEF0
) (
  input logic             clk,
  input logic             rst_n,
  rdout_bank_mgr_if.slave bus
);
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int BANK_W = $clog2(N_BANK);
  localparam int CNT_W  = $clog2(N_BANK + 1);

  logic [BANK_W-1:0] head, tail;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  desc_t             desc [N_BANK];
  logic              busy, empty;

  assign busy        = (count == CNT_W'(N_BANK));
  assign empty       = (count == '0);
  assign bus.wr_busy = busy;
  assign bus.irq     = !empty;

  logic reg_wr_rel, reg_wr_ctrl, flush, clr_ovf, release_ok, commit_ok, commit_drop;
  assign reg_wr_rel  = bus.y_wr && (bus.y_adr == REG_BASE + REG_RELEASE);
  assign reg_wr_ctrl = bus.y_wr && (bus.y_adr == REG_BASE + REG_CTRL);
  assign flush       = reg_wr_ctrl && bus.y_wr_data[CTRL_FLUSH_BIT];
  assign clr_ovf     = reg_wr_ctrl && bus.y_wr_data[CTRL_CLR_OVF_BIT];
  // Legality of commit and release is judged on the count held at the start of the cycle.
  assign release_ok  = reg_wr_rel && bus.y_wr_data[0] && !empty && !flush;
  assign commit_ok   = bus.wr_commit && !busy && !flush;
  assign commit_drop = bus.wr_commit && busy && !flush;

  logic unused_wr_data_bits;
  assign unused_wr_data_bits = &{1'b0, bus.y_wr_data[15:2]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < N_BANK; i++) begin
        desc[i] <= '0;
      end
    end else begin
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (commit_ok) begin
          desc[tail].len <= clamp_len(bus.wr_len, ADDR_W);
          desc[tail].ch  <= DESC_CH_W'(bus.wr_ch[CH_W-1:0]);
          tail           <= tail + 1'b1;
        end
        if (release_ok) begin
          head <= head + 1'b1;
        end
        count <= count + CNT_W'(commit_ok) - CNT_W'(release_ok);
      end
      if (commit_drop) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

  logic [9:0]  word_idx;
  logic        win_sel, win_ok;
  logic [31:0] ram_q;
  assign word_idx = bus.y_adr[10:1];
  assign win_sel  = !bus.y_adr[11];
  assign win_ok   = win_sel && !empty && ((word_idx >> ADDR_W) == '0);

  rdout_bank_ram #(.AW(BANK_W + ADDR_W)) u_ram (
    .clk   (clk),
    .we    (bus.wr_en && !busy),
    .waddr ({tail, bus.wr_addr}),
    .wdata (bus.wr_data),
    .raddr ({head, word_idx[ADDR_W-1:0]}),
    .rdata (ram_q)
  );

  logic [11:0] reg_off;
  logic [15:0] reg_val;
  logic        reg_hit;
  assign reg_off = bus.y_adr - REG_BASE;

  always_comb begin
    reg_val = '0;
    reg_hit = 1'b0;
    if (win_sel) begin
      reg_hit = 1'b1;
    end else begin
      case (reg_off)
        REG_STATUS: begin
          reg_hit                        = 1'b1;
          reg_val[STAT_CNT_LSB +: 4]     = 4'(count);
          reg_val[STAT_OVF_BIT]          = overflow;
          reg_val[STAT_BUSY_BIT]         = busy;
        end
        REG_LEN: begin
          reg_hit = 1'b1;
          if (!empty) reg_val = desc[head].len;
        end
        REG_CH: begin
          reg_hit = 1'b1;
          if (!empty) reg_val = 16'(desc[head].ch);
        end
        REG_RELEASE, REG_CTRL: reg_hit = 1'b1;
        default: ;
      endcase
    end
  end

  // Window data comes straight from the registered RAM port so both paths share one cycle of latency.
  logic        rd_win, rd_hi, rd_hit;
  logic [15:0] rd_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_win <= 1'b0;
      rd_hi  <= 1'b0;
      rd_hit <= 1'b0;
      rd_val <= '0;
    end else begin
      rd_win <= win_ok;
      rd_hi  <= bus.y_adr[0];
      rd_hit <= reg_hit;
      rd_val <= reg_val;
    end
  end

  assign bus.y_rd_hit  = rd_hit;
  assign bus.y_rd_data = rd_win ? (rd_hi ? ram_q[31:16] : ram_q[15:0]) : rd_val;
endmodule

// File: tb/tb_rdout_bank_mgr.sv
// tb/tb_rdout_bank_mgr.sv - directed self-checking bench for rdout_bank_mgr
module tb_rdout_bank_mgr;
  localparam logic [11:0] RB = 12'hEF0;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  rdout_bank_mgr_if #(.ADDR_W(10), .CH_W(2)) bus ();

  rdout_bank_mgr #(.N_BANK(2), .ADDR_W(10), .N_CH(4), .REG_BASE(RB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.wr_commit = 1'b0; bus.wr_len = '0; bus.wr_ch = '0;
    bus.y_adr = 12'hFFF; bus.y_wr = 1'b0; bus.y_wr_data = '0;
  endtask

  task automatic wr_word(input logic [9:0] a, input logic [31:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic commit(input logic [15:0] len, input logic [1:0] ch);
    bus.wr_commit = 1'b1; bus.wr_len = len; bus.wr_ch = ch;
    @(negedge clk);
    bus.wr_commit = 1'b0;
  endtask

  task automatic host_wr(input logic [11:0] a, input logic [15:0] d);
    bus.y_wr = 1'b1; bus.y_adr = a; bus.y_wr_data = d;
    @(negedge clk);
    bus.y_wr = 1'b0; bus.y_adr = 12'hFFF;
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] a, input logic [15:0] exp_d, input logic exp_hit);
    bus.y_adr = a;
    @(negedge clk);
    chk({tag, ".data"}, 32'(bus.y_rd_data), 32'(exp_d));
    chk({tag, ".hit"}, 32'(bus.y_rd_hit), 32'(exp_hit));
    bus.y_adr = 12'hFFF;
  endtask

  initial begin
    idle();
    #1 rst_n = 1'b0;
    #1;
    chk("rst.busy", 32'(bus.wr_busy), 32'd0);
    chk("rst.irq", 32'(bus.irq), 32'd0);
    chk("rst.hit", 32'(bus.y_rd_hit), 32'd0);
    chk("rst.data", 32'(bus.y_rd_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    rd_chk("empty.status", RB + 12'd0, 16'h0000, 1'b1);
    rd_chk("empty.len", RB + 12'd1, 16'h0000, 1'b1);
    rd_chk("empty.win", 12'h001, 16'h0000, 1'b1);
    rd_chk("unmapped.ef8", 12'hEF8, 16'h0000, 1'b0);
    rd_chk("unmapped.800", 12'h800, 16'h0000, 1'b0);

    // first bank: words A5A50000+i, len 8, ch 2
    for (int i = 0; i < 8; i++) wr_word(10'(i), 32'hA5A5_0000 + 32'(i));
    commit(16'd8, 2'd2);
    chk("b0.irq", 32'(bus.irq), 32'd1);
    rd_chk("b0.status", RB + 12'd0, 16'h1000, 1'b1);
    rd_chk("b0.len", RB + 12'd1, 16'd8, 1'b1);
    rd_chk("b0.ch", RB + 12'd2, 16'd2, 1'b1);
    rd_chk("b0.w001", 12'h001, 16'hA5A5, 1'b1);
    rd_chk("b0.w002", 12'h002, 16'h0001, 1'b1);
    rd_chk("b0.w00e", 12'h00E, 16'h0007, 1'b1);
    host_wr(12'h000, 16'hFFFF);
    rd_chk("b0.winwr_ignored", 12'h000, 16'h0000, 1'b1);

    // fill to capacity, then overflow
    wr_word(10'd0, 32'h1111_2222);
    commit(16'd1, 2'd1);
    chk("full.busy", 32'(bus.wr_busy), 32'd1);
    rd_chk("full.status", RB + 12'd0, 16'h2001, 1'b1);
    wr_word(10'd0, 32'hDEAD_BEEF);
    commit(16'd5, 2'd3);
    rd_chk("ovf.status", RB + 12'd0, 16'h2003, 1'b1);
    rd_chk("ovf.head_intact", 12'h000, 16'h0000, 1'b1);
    rd_chk("ovf.len", RB + 12'd1, 16'd8, 1'b1);
    host_wr(RB + 12'd4, 16'h0002);
    rd_chk("clrovf.status", RB + 12'd0, 16'h2001, 1'b1);

    host_wr(RB + 12'd3, 16'h0001);
    rd_chk("rel1.status", RB + 12'd0, 16'h1000, 1'b1);
    rd_chk("rel1.len", RB + 12'd1, 16'd1, 1'b1);
    rd_chk("rel1.ch", RB + 12'd2, 16'd1, 1'b1);
    rd_chk("rel1.w000", 12'h000, 16'h2222, 1'b1);
    rd_chk("rel1.w001", 12'h001, 16'h1111, 1'b1);

    // commit and release in the same cycle at count 1
    wr_word(10'd0, 32'h3333_4444);
    bus.wr_commit = 1'b1; bus.wr_len = 16'd2; bus.wr_ch = 2'd3;
    bus.y_wr = 1'b1; bus.y_adr = RB + 12'd3; bus.y_wr_data = 16'h0001;
    @(negedge clk);
    idle();
    rd_chk("same.status", RB + 12'd0, 16'h1000, 1'b1);
    rd_chk("same.len", RB + 12'd1, 16'd2, 1'b1);
    rd_chk("same.ch", RB + 12'd2, 16'd3, 1'b1);
    rd_chk("same.w000", 12'h000, 16'h4444, 1'b1);

    // oversize length clamps to the bank size; lands in bank 1
    commit(16'hFFFF, 2'd0);
    host_wr(RB + 12'd3, 16'h0001);
    rd_chk("clamp.len", RB + 12'd1, 16'd1024, 1'b1);
    rd_chk("clamp.ch", RB + 12'd2, 16'd0, 1'b1);
    rd_chk("clamp.status", RB + 12'd0, 16'h1000, 1'b1);

    host_wr(RB + 12'd3, 16'h0001);
    host_wr(RB + 12'd3, 16'h0001);
    rd_chk("relempty.status", RB + 12'd0, 16'h0000, 1'b1);
    rd_chk("relempty.len", RB + 12'd1, 16'h0000, 1'b1);
    chk("relempty.irq", 32'(bus.irq), 32'd0);

    // reach count 2 with head=1, tail=1, then reset mid-burst
    wr_word(10'd0, 32'h5555_6666); commit(16'd1, 2'd1);
    wr_word(10'd0, 32'h9999_AAAA); commit(16'd1, 2'd2);
    host_wr(RB + 12'd3, 16'h0001);
    wr_word(10'd0, 32'hBBBB_CCCC); commit(16'd1, 2'd3);
    rd_chk("prerst.status", RB + 12'd0, 16'h2001, 1'b1);
    bus.wr_en = 1'b1; bus.wr_addr = 10'd3; bus.wr_data = 32'hDEAD_0003;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst.busy", 32'(bus.wr_busy), 32'd0);
    chk("midrst.irq", 32'(bus.irq), 32'd0);
    chk("midrst.hit", 32'(bus.y_rd_hit), 32'd0);
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    @(negedge clk);
    rd_chk("postrst.status", RB + 12'd0, 16'h0000, 1'b1);
    wr_word(10'd0, 32'h7777_8888);
    commit(16'd1, 2'd1);
    rd_chk("postrst.w000", 12'h000, 16'h8888, 1'b1);
    rd_chk("postrst.ch", RB + 12'd2, 16'd1, 1'b1);
    host_wr(RB + 12'd3, 16'h0001);

    // rolling fill/release with the queue one ahead, wrapping both pointers
    wr_word(10'd5, {16'hC0D0, 16'hB000});
    commit(16'd3, 2'd0);
    for (int i = 1; i <= 4; i++) begin
      wr_word(10'd5, {16'hC0D0 + 16'(i), 16'hB000 + 16'(i)});
      commit(16'(i + 3), 2'(i));
      rd_chk($sformatf("roll%0d.len", i), RB + 12'd1, 16'(i + 2), 1'b1);
      rd_chk($sformatf("roll%0d.ch", i), RB + 12'd2, 16'((i - 1) % 4), 1'b1);
      rd_chk($sformatf("roll%0d.lo", i), 12'h00A, 16'hB000 + 16'(i - 1), 1'b1);
      rd_chk($sformatf("roll%0d.hi", i), 12'h00B, 16'hC0D0 + 16'(i - 1), 1'b1);
      host_wr(RB + 12'd3, 16'h0001);
    end
    rd_chk("roll_last.lo", 12'h00A, 16'hB004, 1'b1);
    rd_chk("roll_last.ch", RB + 12'd2, 16'd0, 1'b1);
    host_wr(RB + 12'd3, 16'h0001);
    rd_chk("roll_end.status", RB + 12'd0, 16'h0000, 1'b1);

    // flush beats a same-cycle commit at full count without setting overflow
    commit(16'd1, 2'd1);
    commit(16'd1, 2'd2);
    bus.wr_commit = 1'b1; bus.wr_len = 16'd4; bus.wr_ch = 2'd3;
    bus.y_wr = 1'b1; bus.y_adr = RB + 12'd4; bus.y_wr_data = 16'h0001;
    @(negedge clk);
    idle();
    rd_chk("flush.status", RB + 12'd0, 16'h0000, 1'b1);
    chk("flush.irq", 32'(bus.irq), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
